// File: rtl/nkmm_daspc_seq_if.sv
// nkmm_daspc_seq_if: job control, operand-read issue, product return and
// result hand-off signals of the nkmm_daspc_seq accumulate sequencer.
//
// Result handshake (valid/ready): a result transfers on a rising edge where
// result_valid_o and result_ready_i are both 1. Once result_valid_o is
// raised it stays high and result_o stays unchanged until that transfer.
// result_ready_i may be raised before result_valid_o and may be held high.
interface nkmm_daspc_seq_if;
    logic        start_i;
    logic [7:0]  mpcand_base_i;
    logic [11:0] mplier_base_i;
    logic [7:0]  ntaps_i;
    logic        mpcand_dec_i;
    logic        busy_o;
    logic [7:0]  mpcand_addr_o;
    logic [11:0] mplier_addr_o;
    logic        rd_en_o;
    logic [31:0] prod_i;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        result_ready_i;

    // Sequencer side.
    modport slave (
        input  start_i, mpcand_base_i, mplier_base_i, ntaps_i, mpcand_dec_i,
        input  prod_i, result_ready_i,
        output busy_o, mpcand_addr_o, mplier_addr_o, rd_en_o,
        output result_o, result_valid_o
    );

    // Controller / memory / multiplier side.
    modport master (
        output start_i, mpcand_base_i, mplier_base_i, ntaps_i, mpcand_dec_i,
        output prod_i, result_ready_i,
        input  busy_o, mpcand_addr_o, mplier_addr_o, rd_en_o,
        input  result_o, result_valid_o
    );
endinterface

// File: rtl/nkmm_daspc_seq.sv
// nkmm_daspc_seq: issues ntaps operand reads (multiplicand walking up or down,
// multiplier walking up), accumulates the signed products that come back
// PIPE_LAT cycles later, and hands the 32-bit result over a valid/ready port.
// Optional macro DASPC_SEQ_SAT_EN: clamp result_o to the signed 32-bit range
// instead of taking the low 32 accumulator bits.
// PIPE_LAT must be at least 2; ACC_W must be at least 33.
module nkmm_daspc_seq #(
    parameter int PIPE_LAT = 7,
    parameter int ACC_W    = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    nkmm_daspc_seq_if.slave      bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_remaining;
    logic [7:0]              r_mpcand_addr;
    logic [11:0]             r_mplier_addr;
    logic                    r_dec;
    logic [PIPE_LAT-1:0]     r_vpipe;
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_busy;
    logic                    w_rd_en;
    logic                    w_valid;
    logic                    w_start;
    logic                    w_last_issue;
    logic                    w_prod_vld;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic [31:0]             w_result;

    assign w_start      = (r_state == S_IDLE) && bus.start_i;
    assign w_last_issue = w_rd_en && (r_remaining == 8'd1);
    assign w_prod_vld   = r_vpipe[PIPE_LAT-1];
    assign w_prod_ext   = {{(ACC_W-32){bus.prod_i[31]}}, bus.prod_i};

    // State register; reset overrides everything and abandons any job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_rd_en     = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start_i) begin
                    w_state_nxt = (bus.ntaps_i == 8'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_rd_en = 1'b1;
                if (r_remaining == 8'd1) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Empty tracker means the last product was added last edge.
                if (r_vpipe == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_valid = 1'b1;
                if (bus.result_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job latch and address walk; addresses hold the last issued value in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining   <= 8'd0;
            r_mpcand_addr <= 8'd0;
            r_mplier_addr <= 12'd0;
            r_dec         <= 1'b0;
        end else if (w_start) begin
            r_remaining   <= bus.ntaps_i;
            r_mpcand_addr <= bus.mpcand_base_i;
            r_mplier_addr <= bus.mplier_base_i;
            r_dec         <= bus.mpcand_dec_i;
        end else if (w_rd_en) begin
            r_remaining <= r_remaining - 8'd1;
            if (!w_last_issue) begin
                r_mpcand_addr <= r_dec ? (r_mpcand_addr - 8'd1) : (r_mpcand_addr + 8'd1);
                r_mplier_addr <= r_mplier_addr + 12'd1;
            end
        end
    end

    // Valid tracker: bit PIPE_LAT-1 marks the cycle a product is on prod_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe <= {r_vpipe[PIPE_LAT-2:0], w_rd_en};
        end
    end

    // Accumulator: cleared on job start, adds only tracked products.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_start) begin
            r_acc <= '0;
        end else if (w_prod_vld) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

`ifdef DASPC_SEQ_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    // Clamp the wide accumulator into the signed 32-bit result range.
    always_comb begin
        w_result = r_acc[31:0];
        if (r_acc > ACC_MAX) begin
            w_result = 32'h7FFF_FFFF;
        end else if (r_acc < ACC_MIN) begin
            w_result = 32'h8000_0000;
        end
    end
`else
    // Two's-complement wrap: the upper accumulator bits are simply dropped.
    logic w_unused_acc_hi;
    assign w_result        = r_acc[31:0];
    assign w_unused_acc_hi = ^r_acc[ACC_W-1:32];
`endif

    assign bus.busy_o         = w_busy;
    assign bus.rd_en_o        = w_rd_en;
    assign bus.result_valid_o = w_valid;
    assign bus.mpcand_addr_o  = r_mpcand_addr;
    assign bus.mplier_addr_o  = r_mplier_addr;
    assign bus.result_o       = w_result;
    assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_nkmm_daspc_seq.sv
// tb_nkmm_daspc_seq: scenario tasks for the nkmm_daspc_seq accumulate sequencer.
// Products are returned by a small multiplier model PIPE_LAT cycles after each
// observed rd_en_o; expected results come from summing the issued values.
module tb_nkmm_daspc_seq;
    localparam int PIPE_LAT = 7;
    localparam int ACC_W    = 40;

    // Clock / reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    nkmm_daspc_seq_if bus();

    nkmm_daspc_seq #(.PIPE_LAT(PIPE_LAT), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // Observation state filled by the monitor.
    int          ncyc       = 0;
    int          start_cyc  = 0;
    int          rise_cyc   = -1;
    int          rise_count = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  mc_q[$];
    logic [11:0] ml_q[$];
    // Multiplier model: values to return and when.
    int          due_q[$];
    logic [31:0] dval_q[$];
    logic [31:0] src_q[$];
    // Scoreboard of expected results.
    logic [31:0] exp_q[$];

    // Monitor: log issued addresses, schedule product returns, note valid rises.
    initial forever begin
        @(negedge clk);
        ncyc++;
        if (bus.rd_en_o === 1'b1) begin
            mc_q.push_back(bus.mpcand_addr_o);
            ml_q.push_back(bus.mplier_addr_o);
            due_q.push_back(ncyc + PIPE_LAT);
            if (src_q.size() != 0) dval_q.push_back(src_q.pop_front());
            else dval_q.push_back($urandom());
        end
        if (bus.result_valid_o === 1'b1 && prev_valid !== 1'b1) begin
            rise_cyc = ncyc;
            rise_count++;
        end
        prev_valid = bus.result_valid_o;
    end

    // Product driver: garbage on prod_i except in a product's return cycle.
    initial begin
        bus.prod_i = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (due_q.size() != 0 && due_q[0] == ncyc + 1) begin
                bus.prod_i = dval_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                bus.prod_i = $urandom();
            end
        end
    end

    // Reference model
    function automatic logic [31:0] model_result(input longint sum);
`ifdef DASPC_SEQ_SAT_EN
        if (sum > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (sum < -64'sd2147483648) return 32'h8000_0000;
`endif
        return sum[31:0];
    endfunction

    function automatic logic [7:0] model_mc(input logic [7:0] base, input logic dec, input int k);
        int a;
        a = dec ? (int'(base) - k) : (int'(base) + k);
        return 8'(a & 255);
    endfunction

    function automatic logic [11:0] model_ml(input logic [11:0] base, input int k);
        return 12'((int'(base) + k) & 4095);
    endfunction

    function automatic int model_lat(input int n);
        return (n == 0) ? 0 : n + PIPE_LAT + 1;
    endfunction

    // Driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] mb, input logic [11:0] pb, input logic [7:0] n, input logic dec);
        mc_q.delete();
        ml_q.delete();
        rise_cyc              = -1;
        bus.mpcand_base_i     = mb;
        bus.mplier_base_i     = pb;
        bus.ntaps_i           = n;
        bus.mpcand_dec_i      = dec;
        bus.start_i           = 1'b1;
        start_cyc             = ncyc;
        tick();
        bus.start_i           = 1'b0;
        bus.mpcand_base_i     = 8'($urandom());
        bus.mplier_base_i     = 12'($urandom());
        bus.ntaps_i           = 8'($urandom());
        bus.mpcand_dec_i      = 1'($urandom());
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.result_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        checks++; if (bus.rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", bus.rd_en_o); end
        checks++; if (bus.result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.result_valid_o); end
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
        checks++; if (bus.mpcand_addr_o !== 8'd0 || bus.mplier_addr_o !== 12'd0) begin
            errors++; $display("FAIL reset_addr: got %h/%h expected 00/000", bus.mpcand_addr_o, bus.mplier_addr_o);
        end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_dbg_state: got %0d expected 0", dbg_state); end
        rst = 1'b0;
        tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: got busy %b expected 0", bus.busy_o); end
    endtask

    task automatic test_basic();
        bit     ok;
        longint sum;
        sum = 0;
        for (int k = 1; k <= 4; k++) begin
            src_q.push_back(32'(k));
            sum += k;
        end
        exp_q.push_back(model_result(sum));
        bus.result_ready_i = 1'b0;
        launch(8'h00, 12'h000, 8'd4, 1'b0);
        checks++; if (bus.rd_en_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            errors++; $display("FAIL basic_first_issue: got rd_en %b busy %b expected 1 1", bus.rd_en_o, bus.busy_o);
        end
        wait_valid(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got no result_valid_o expected one within 60 cycles"); end
        checks++; if (rise_cyc - start_cyc - 1 != 12) begin
            errors++; $display("FAIL basic_latency: got %0d expected 12", rise_cyc - start_cyc - 1);
        end
        checks++; if (mc_q.size() != 4) begin errors++; $display("FAIL basic_issue_count: got %0d expected 4", mc_q.size()); end
        for (int k = 0; k < mc_q.size(); k++) begin
            checks++; if (mc_q[k] !== 8'(k) || ml_q[k] !== 12'(k)) begin
                errors++; $display("FAIL basic_addr[%0d]: got %h/%h expected %h/%h", k, mc_q[k], ml_q[k], 8'(k), 12'(k));
            end
        end
        checks++; if (bus.result_o !== exp_q[0]) begin errors++; $display("FAIL basic_result: got %h expected %h", bus.result_o, exp_q[0]); end
        void'(exp_q.pop_front());
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        checks++; if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL basic_accept: got valid %b busy %b expected 0 0", bus.result_valid_o, bus.busy_o);
        end
    endtask

    task automatic test_wrap();
        bit          ok;
        longint      sum;
        logic [31:0] v;
        logic [7:0]  emc[4];
        logic [11:0] eml[4];
        emc = '{8'h02, 8'h01, 8'h00, 8'hFF};
        eml = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            v = $urandom();
            src_q.push_back(v);
            sum += longint'($signed(v));
        end
        exp_q.push_back(model_result(sum));
        bus.result_ready_i = 1'b1;
        launch(8'h02, 12'hFFE, 8'd4, 1'b1);
        wait_valid(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got no result_valid_o expected one within 60 cycles"); end
        checks++; if (mc_q.size() != 4) begin errors++; $display("FAIL wrap_issue_count: got %0d expected 4", mc_q.size()); end
        for (int k = 0; k < mc_q.size() && k < 4; k++) begin
            checks++; if (mc_q[k] !== emc[k] || ml_q[k] !== eml[k]) begin
                errors++; $display("FAIL wrap_addr[%0d]: got %h/%h expected %h/%h", k, mc_q[k], ml_q[k], emc[k], eml[k]);
            end
        end
        checks++; if (bus.result_o !== exp_q[0]) begin errors++; $display("FAIL wrap_result: got %h expected %h", bus.result_o, exp_q[0]); end
        void'(exp_q.pop_front());
        tick();
        bus.result_ready_i = 1'b0;
        checks++; if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL wrap_done_one_cycle: got valid %b busy %b expected 0 0", bus.result_valid_o, bus.busy_o);
        end
    endtask

    task automatic test_zero_backpressure();
        bus.result_ready_i = 1'b0;
        launch(8'($urandom()), 12'($urandom()), 8'd0, 1'($urandom()));
        checks++; if (bus.result_valid_o !== 1'b1 || bus.rd_en_o !== 1'b0) begin
            errors++; $display("FAIL zero_valid_next: got valid %b rd_en %b expected 1 0", bus.result_valid_o, bus.rd_en_o);
        end
        checks++; if (bus.result_o !== model_result(0)) begin errors++; $display("FAIL zero_result: got %h expected %h", bus.result_o, model_result(0)); end
        checks++; if (rise_cyc - start_cyc - 1 != 0) begin errors++; $display("FAIL zero_latency: got %0d expected 0", rise_cyc - start_cyc - 1); end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (bus.result_valid_o !== 1'b1 || bus.result_o !== 32'd0 || bus.busy_o !== 1'b1) begin
                errors++; $display("FAIL zero_hold[%0d]: got valid %b result %h busy %b expected 1 00000000 1", c, bus.result_valid_o, bus.result_o, bus.busy_o);
            end
        end
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        checks++; if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL zero_accept: got valid %b busy %b expected 0 0", bus.result_valid_o, bus.busy_o);
        end
        checks++; if (mc_q.size() != 0) begin errors++; $display("FAIL zero_no_issue: got %0d issues expected 0", mc_q.size()); end
    endtask

    task automatic test_saturation();
        bit          ok;
        longint      sum;
        logic [31:0] v;
        logic [31:0] spec_pos;
`ifdef DASPC_SEQ_SAT_EN
        spec_pos = 32'h7FFF_FFFF;
`else
        spec_pos = 32'h7FFF_FFFD;
`endif
        for (int pass = 0; pass < 2; pass++) begin
            v = (pass == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            sum = 0;
            for (int k = 0; k < 3; k++) begin
                src_q.push_back(v);
                sum += longint'($signed(v));
            end
            exp_q.push_back(model_result(sum));
            bus.result_ready_i = 1'b0;
            launch(8'($urandom()), 12'($urandom()), 8'd3, 1'($urandom()));
            wait_valid(60, ok);
            checks++; if (!ok) begin errors++; $display("FAIL sat_timeout[%0d]: got no result_valid_o expected one", pass); end
            checks++; if (bus.result_o !== exp_q[0]) begin
                errors++; $display("FAIL sat_result[%0d]: got %h expected %h", pass, bus.result_o, exp_q[0]);
            end
            if (pass == 0) begin
                checks++; if (bus.result_o !== spec_pos) begin errors++; $display("FAIL sat_pos_const: got %h expected %h", bus.result_o, spec_pos); end
            end
            void'(exp_q.pop_front());
            bus.result_ready_i = 1'b1;
            tick();
            bus.result_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset_midop();
        bit          ok;
        longint      sum;
        logic [31:0] v;
        logic [7:0]  mb;
        logic [11:0] pb;
        logic        dec;
        for (int k = 0; k < 8; k++) src_q.push_back($urandom());
        bus.result_ready_i = 1'b0;
        launch(8'($urandom()), 12'($urandom()), 8'd8, 1'($urandom()));
        for (int i = 0; i < 10 && mc_q.size() < 3; i++) tick();
        checks++; if (mc_q.size() != 3) begin errors++; $display("FAIL midop_third_issue: got %0d issues expected 3", mc_q.size()); end
        rst = 1'b1;
        tick();
        checks++; if (bus.busy_o !== 1'b0 || bus.rd_en_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
            errors++; $display("FAIL midop_ctrl: got busy %b rd_en %b valid %b expected 0 0 0", bus.busy_o, bus.rd_en_o, bus.result_valid_o);
        end
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL midop_result: got %h expected 0", bus.result_o); end
        checks++; if (bus.mpcand_addr_o !== 8'd0 || bus.mplier_addr_o !== 12'd0) begin
            errors++; $display("FAIL midop_addr: got %h/%h expected 00/000", bus.mpcand_addr_o, bus.mplier_addr_o);
        end
        rst = 1'b0;
        src_q.delete();
        // Fresh job while the abandoned job's products are still returning.
        mb  = 8'($urandom());
        pb  = 12'($urandom());
        dec = 1'($urandom());
        sum = 0;
        for (int k = 0; k < 5; k++) begin
            v = $urandom();
            src_q.push_back(v);
            sum += longint'($signed(v));
        end
        exp_q.push_back(model_result(sum));
        launch(mb, pb, 8'd5, dec);
        wait_valid(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midop_timeout: got no result_valid_o expected one"); end
        checks++; if (mc_q.size() != 5 || mc_q[0] !== mb || ml_q[0] !== pb) begin
            errors++; $display("FAIL midop_restart_issue: got %0d issues expected 5 from %h/%h", mc_q.size(), mb, pb);
        end
        checks++; if (bus.result_o !== exp_q[0]) begin errors++; $display("FAIL midop_new_result: got %h expected %h", bus.result_o, exp_q[0]); end
        void'(exp_q.pop_front());
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
    endtask

    task automatic test_ignored_start();
        bit          ok;
        longint      sum;
        logic [31:0] v;
        int          rise_before;
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            v = $urandom();
            src_q.push_back(v);
            sum += longint'($signed(v));
        end
        exp_q.push_back(model_result(sum));
        bus.result_ready_i = 1'b0;
        rise_before = rise_count;
        launch(8'($urandom()), 12'($urandom()), 8'd4, 1'($urandom()));
        tick();
        bus.ntaps_i = 8'd0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 10 && bus.rd_en_o === 1'b1; i++) tick();
        tick();
        bus.ntaps_i = 8'd2;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        wait_valid(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_timeout: got no result_valid_o expected one"); end
        checks++; if (bus.result_o !== exp_q[0]) begin errors++; $display("FAIL ign_result: got %h expected %h", bus.result_o, exp_q[0]); end
        void'(exp_q.pop_front());
        // Start raised together with the accepting ready must also be dropped.
        bus.ntaps_i        = 8'd3;
        bus.start_i        = 1'b1;
        bus.result_ready_i = 1'b1;
        tick();
        bus.start_i        = 1'b0;
        bus.result_ready_i = 1'b0;
        checks++; if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
            errors++; $display("FAIL ign_done_start: got busy %b valid %b expected 0 0", bus.busy_o, bus.result_valid_o);
        end
        repeat (12) tick();
        checks++; if (rise_count != rise_before + 1) begin
            errors++; $display("FAIL ign_one_result: got %0d results expected 1", rise_count - rise_before);
        end
        checks++; if (mc_q.size() != 4 || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL ign_no_second_job: got %0d issues busy %b expected 4 0", mc_q.size(), bus.busy_o);
        end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        bit          pre;
        longint      sum;
        logic [31:0] v;
        logic [31:0] held;
        logic [7:0]  mb;
        logic [11:0] pb;
        logic        dec;
        int          n;
        for (int j = 0; j < 12; j++) begin
            n   = $urandom_range(0, 12);
            mb  = 8'($urandom());
            pb  = 12'($urandom());
            dec = 1'($urandom());
            pre = ($urandom_range(0, 2) == 0);
            sum = 0;
            src_q.delete();
            for (int k = 0; k < n; k++) begin
                v = $urandom();
                src_q.push_back(v);
                sum += longint'($signed(v));
            end
            exp_q.push_back(model_result(sum));
            bus.result_ready_i = pre;
            launch(mb, pb, 8'(n), dec);
            wait_valid(80, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout[%0d]: got no result_valid_o expected one", j); end
            checks++; if (rise_cyc - start_cyc - 1 != model_lat(n)) begin
                errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", j, rise_cyc - start_cyc - 1, model_lat(n));
            end
            checks++; if (mc_q.size() != n) begin errors++; $display("FAIL b2b_issue_count[%0d]: got %0d expected %0d", j, mc_q.size(), n); end
            for (int k = 0; k < mc_q.size(); k++) begin
                checks++; if (mc_q[k] !== model_mc(mb, dec, k) || ml_q[k] !== model_ml(pb, k)) begin
                    errors++; $display("FAIL b2b_addr[%0d.%0d]: got %h/%h expected %h/%h", j, k, mc_q[k], ml_q[k], model_mc(mb, dec, k), model_ml(pb, k));
                end
            end
            checks++; if (bus.result_o !== exp_q[0]) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", j, bus.result_o, exp_q[0]); end
            void'(exp_q.pop_front());
            if (pre) begin
                tick();
                checks++; if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                    errors++; $display("FAIL b2b_done_one_cycle[%0d]: got valid %b busy %b expected 0 0", j, bus.result_valid_o, bus.busy_o);
                end
            end else begin
                held = bus.result_o;
                repeat ($urandom_range(1, 4)) begin
                    tick();
                    checks++; if (bus.result_valid_o !== 1'b1 || bus.result_o !== held) begin
                        errors++; $display("FAIL b2b_hold[%0d]: got valid %b result %h expected 1 %h", j, bus.result_valid_o, bus.result_o, held);
                    end
                end
                bus.result_ready_i = 1'b1;
                tick();
                checks++; if (bus.result_valid_o !== 1'b0) begin
                    errors++; $display("FAIL b2b_accept[%0d]: got valid %b expected 0", j, bus.result_valid_o);
                end
            end
            bus.result_ready_i = 1'b0;
        end
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run expected finish before 50000 cycles");
        $fatal(1);
    end

    initial begin
        bus.start_i        = 1'b0;
        bus.mpcand_base_i  = 8'd0;
        bus.mplier_base_i  = 12'd0;
        bus.ntaps_i        = 8'd0;
        bus.mpcand_dec_i   = 1'b0;
        bus.result_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero_backpressure();
        test_saturation();
        test_reset_midop();
        test_ignored_start();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nkmm_daspc_seq.md
NKMM_DASPC_SEQ -- requirements
Module: nkmm_daspc_seq

Interface
REQ-001 The block SHALL have parameter PIPE_LAT, default 7, meaning cycles from rd_en_o to the matching prod_i (1 memread + 1 mul + 5 multiplier delay).
REQ-002 The block SHALL have parameter ACC_W, default 40, meaning accumulator width in bits (ACC_W >= 33).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 The block SHALL have port start_i, input, 1, start request; accepted only in IDLE.
REQ-006 The block SHALL have port mpcand_base_i, input, 8, first mpcand address.
REQ-007 The block SHALL have port mplier_base_i, input, 12, first mplier address.
REQ-008 The block SHALL have port ntaps_i, input, 8, number of products to accumulate.
REQ-009 The block SHALL have port mpcand_dec_i, input, 1, mpcand walk direction (1 = decrement, 0 = increment).
REQ-010 The block SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-011 The block SHALL have port mpcand_addr_o, output, 8, registered mpcand read address.
REQ-012 The block SHALL have port mplier_addr_o, output, 12, registered mplier read address.
REQ-013 The block SHALL have port rd_en_o, output, 1, a read/multiply is issued this cycle.
REQ-014 The block SHALL have port prod_i, input, 32, signed product returned PIPE_LAT cycles after its rd_en_o.
REQ-015 The block SHALL have port result_o, output, 32, signed accumulated result.
REQ-016 The block SHALL have port result_valid_o, output, 1, result_o is valid.
REQ-017 The block SHALL have port result_ready_i, input, 1, consumer accepts the result.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-019 In IDLE, start_i=1 SHALL latch the bases, direction and ntaps_i, and SHALL clear the accumulator. The next state is ISSUE, or DONE with result 0 if ntaps_i=0.
REQ-020 In ISSUE, rd_en_o SHALL be 1 for exactly ntaps consecutive cycles, starting the cycle after start_i is sampled. The first issue uses the base addresses.
REQ-021 Per issue, mpcand_addr_o SHALL step by +/-1 modulo 256 and mplier_addr_o SHALL step by +1 modulo 4096; wrap-around is silent.
REQ-022 After the last issue the FSM SHALL enter DRAIN. rd_en_o=0 and the addresses hold.
REQ-023 A PIPE_LAT-deep valid shift register SHALL track rd_en_o. When its output is 1, the block SHALL add sign-extended prod_i to the ACC_W-bit accumulator. prod_i is ignored otherwise.
REQ-024 DRAIN SHALL exit to DONE on the cycle after the last valid product is accumulated. result_valid_o rises ntaps+PIPE_LAT+1 cycles after the start_i sampling edge.
REQ-025 In DONE, result_valid_o SHALL be 1 and result_o SHALL be stable until result_valid_o and result_ready_i are both 1 at an edge, then the FSM SHALL return to IDLE.
REQ-026 If result_ready_i is already 1 on entering DONE, DONE SHALL last exactly one cycle.
REQ-027 start_i SHALL be ignored outside IDLE and is not queued. start_i in the same cycle as the DONE handshake is ignored.

Reset
REQ-028 On rst=1 at an edge, the block SHALL reset to: state IDLE, busy_o=0, rd_en_o=0, result_valid_o=0, result_o=0, both addresses 0, accumulator and valid pipeline cleared.
REQ-029 rst SHALL take priority over all other inputs. Reset mid-ISSUE or mid-DRAIN abandons the job, and products still in flight are discarded.

Configuration
REQ-030 With macro DASPC_SEQ_SAT_EN defined, result_o SHALL be the accumulator clamped to [-2^31, 2^31-1].
REQ-031 Without DASPC_SEQ_SAT_EN, result_o SHALL be accumulator bits [31:0] (two's-complement wrap).

Verification
REQ-032 Basic: base 0/0, increment, ntaps=4, prod_i=1,2,3,4 aligned to rd_en -> mpcand_addr_o 0,1,2,3; result_o=10; result_valid_o rises at start+12.
REQ-033 Wrap: mpcand_base=0x02 with decrement, mplier_base=0xFFE, ntaps=4 -> mpcand addresses 02,01,00,FF; mplier addresses FFE,FFF,000,001.
REQ-034 Zero taps and backpressure: ntaps=0 -> no rd_en_o, result_o=0 and valid the next cycle. Then result_ready_i held 0 for 5 cycles -> result_o stable and valid held, IDLE after ready.
REQ-035 Saturation: ntaps=3, prod_i=0x7FFFFFFF each -> result_o=0x7FFFFFFF with DASPC_SEQ_SAT_EN, 0x7FFFFFFD without.
REQ-036 Reset mid-op: rst asserted during the 3rd issue cycle of ntaps=8 -> all outputs 0 the next cycle. A new start then gives a correct result unaffected by stale products.
REQ-037 Ignored start: start_i pulsed during ISSUE and DRAIN -> no second job; exactly one result is produced.
